// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage core: forwarding selects, stage stall/flush, memory wait FSM.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt,
    output logic [CNT_W-1:0] LoadUseCnt
);

    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERROR    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_stall;
    logic              load_use;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                           input logic we_m, input logic [4:0] rd_w,
                                           input logic we_w);
        if (we_m && (rd_m != 5'd0) && (rd_m == rs))
            return 2'b10;
        else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_stall  = 1'b0;
        MemErr     = 1'b0;
        case (state_q)
            S_RUN: begin
                if (MemReqM && !MemReadyM) begin
                    mem_stall  = 1'b1;
                    state_d    = S_MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            S_MEM_WAIT: begin
                if (MemReadyM) begin
                    state_d = S_RUN;
                end else begin
                    mem_stall = 1'b1;
                    if ((MEM_TIMEOUT != 0) && (wait_cnt_q == WAIT_LAST))
                        state_d = S_ERROR;
                    else
                        wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_ERROR: begin
                mem_stall = 1'b1;
                MemErr    = 1'b1;
            end
            default: state_d = S_RUN;
        endcase
    end

    assign load_use = ResultSrcE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // Priority: memory freeze, then taken branch, then load-use. Everything is quiet in reset.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        if (!rst) begin
            ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
            ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] load_use_cnt_q, load_use_cnt_d;
    logic             load_use_applied;

    assign load_use_applied = load_use && !mem_stall && !PCSrcE;

    always_comb begin
        stall_cnt_d    = stall_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        load_use_cnt_d = load_use_cnt_q;
        if (StallF || StallD || StallE || StallM)
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (FlushD || FlushE)
            flush_cnt_d = flush_cnt_q + 1'b1;
        if (load_use_applied)
            load_use_cnt_d = load_use_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q    <= '0;
            flush_cnt_q    <= '0;
            load_use_cnt_q <= '0;
        end else begin
            stall_cnt_q    <= stall_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
            load_use_cnt_q <= load_use_cnt_d;
        end
    end

    assign StallCnt   = stall_cnt_q;
    assign FlushCnt   = flush_cnt_q;
    assign LoadUseCnt = load_use_cnt_q;
`else
    assign StallCnt   = '0;
    assign FlushCnt   = '0;
    assign LoadUseCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4); counter expectations
// follow whether HAZARD_PERF_CNT_EN is defined for the build.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        ResultSrcE, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
    logic [31:0] StallCnt, FlushCnt, LoadUseCnt;

    int checks = 0;
    int failures = 0;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt), .LoadUseCnt(LoadUseCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    function automatic logic [3:0] stalls();
        return {StallF, StallD, StallE, StallM};
    endfunction

    function automatic logic [2:0] flushes();
        return {FlushD, FlushE, FlushW};
    endfunction

    initial begin
        clear_inputs();
        rst = 1'b1;
        RdM = 5; RegWriteM = 1; Rs1E = 5; MemReqM = 1;
        #2;
        check("rst_fwd_a", 32'(ForwardAE), 32'h0);
        check("rst_stalls", 32'(stalls()), 32'h0);
        check("rst_memerr", 32'(MemErr), 32'h0);
        check("rst_stallcnt", StallCnt, 32'h0);
        next_cycle();
        next_cycle();
        clear_inputs();
        rst = 1'b0;

        // forwarding priority
        next_cycle();
        RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1; Rs1E = 5;
        #1 check("fwd_mem", 32'(ForwardAE), 32'h2);
        RegWriteM = 0;
        #1 check("fwd_wb", 32'(ForwardAE), 32'h1);
        RdM = 0; RdW = 0;
        #1 check("fwd_x0", 32'(ForwardAE), 32'h0);
        RdM = 7; RdW = 7; RegWriteM = 1; Rs2E = 7; Rs1E = 0;
        #1 check("fwd_b_mem", 32'(ForwardBE), 32'h2);
        check("fwd_a_rs0", 32'(ForwardAE), 32'h0);

        // load-use
        next_cycle();
        clear_inputs();
        ResultSrcE = 1; RdE = 3; Rs2D = 3;
        #1 check("lu_stalls", 32'(stalls()), 32'hC);
        check("lu_flushes", 32'(flushes()), 32'h2);
        next_cycle();
        clear_inputs();
        #1 check("lu_after_stalls", 32'(stalls()), 32'h0);
        check("lu_after_flushes", 32'(flushes()), 32'h0);
        check("lu_cnt", LoadUseCnt, 32'(PERF));
        check("lu_flushcnt", FlushCnt, 32'(PERF));

        // branch beats load-use
        next_cycle();
        ResultSrcE = 1; RdE = 3; Rs1D = 3; PCSrcE = 1;
        #1 check("br_stalls", 32'(stalls()), 32'h0);
        check("br_flushes", 32'(flushes()), 32'h6);
        next_cycle();
        clear_inputs();
        #1 check("br_lucnt", LoadUseCnt, 32'(PERF));
        check("br_flushcnt", FlushCnt, 32'(2 * PERF));

        // clean counters before the memory test
        rst = 1'b1;
        #1 check("rst2_flushcnt", FlushCnt, 32'h0);
        next_cycle();
        rst = 1'b0;

        // memory wait: 3 not-ready cycles
        next_cycle();
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                PCSrcE = 1; RdM = 9; RegWriteM = 1; Rs1E = 9;
            end
            #1 check($sformatf("mw_stalls_%0d", i), 32'(stalls()), 32'hF);
            check($sformatf("mw_flushes_%0d", i), 32'(flushes()), 32'h1);
            if (i == 1) check("mw_fwd_live", 32'(ForwardAE), 32'h2);
            next_cycle();
        end
        MemReadyM = 1;
        #1 check("mw_release_stalls", 32'(stalls()), 32'h0);
        check("mw_release_branch", 32'(flushes()), 32'h6);
        next_cycle();
        clear_inputs();
        #1 check("mw_clear_stalls", 32'(stalls()), 32'h0);
        check("mw_stallcnt", StallCnt, 32'(3 * PERF));

        // ready on first cycle: no stall
        MemReqM = 1; MemReadyM = 1;
        #1 check("mw_ready_first", 32'(stalls()), 32'h0);
        next_cycle();

        // timeout
        MemReqM = 1; MemReadyM = 0;
        #1 check("to_run_stall", 32'(stalls()), 32'hF);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            #1 check($sformatf("to_wait_stall_%0d", i), 32'(stalls()), 32'hF);
            check($sformatf("to_wait_err_%0d", i), 32'(MemErr), 32'h0);
        end
        next_cycle();
        MemReadyM = 1; MemReqM = 0;
        #1 check("to_err", 32'(MemErr), 32'h1);
        check("to_err_stalls", 32'(stalls()), 32'hF);
        check("to_err_flushes", 32'(flushes()), 32'h1);
        next_cycle();
        #1 check("to_err_sticky", 32'(MemErr), 32'h1);
        rst = 1'b1;
        #1 check("to_rst_err", 32'(MemErr), 32'h0);
        check("to_rst_stalls", 32'(stalls()), 32'h0);
        next_cycle();
        rst = 1'b0;
        clear_inputs();
        #1 check("to_run_clear", 32'(stalls()), 32'h0);

        // reset mid-wait
        next_cycle();
        MemReqM = 1; MemReadyM = 0;
        next_cycle();
        #1 check("rw_wait_stall", 32'(stalls()), 32'hF);
        check("rw_stallcnt", StallCnt, 32'(PERF));
        #2 rst = 1'b1;
        #1 check("rw_rst_stalls", 32'(stalls()), 32'h0);
        check("rw_rst_flushes", 32'(flushes()), 32'h0);
        check("rw_rst_stallcnt", StallCnt, 32'h0);
        next_cycle();
        rst = 1'b0;
        MemReqM = 0; MemReadyM = 0;
        #1 check("rw_back_in_run", 32'(stalls()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

endmodule
